// File: rtl/regfile_exec_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : regfile_exec_seq                                                  |
// | Brief   : Four-cycle execute sequencer driving an 8x32 register file:       |
// |           IDLE -> READ -> EXEC -> WB, one instruction in flight.            |
// |           Optional macro SEQ_OVF_EN: signed ADD/SUB overflow suppresses WB. |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module regfile_exec_seq #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [15:0]   imm,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  output logic          we,
  output logic [AW-1:0] addr_w,
  output logic [DW-1:0] d,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_READ = 2'd1;
  localparam logic [1:0] C_EXEC = 2'd2;
  localparam logic [1:0] C_WB   = 2'd3;

  localparam logic [2:0] C_OP_ADD = 3'b000;
  localparam logic [2:0] C_OP_SUB = 3'b001;
  localparam logic [2:0] C_OP_AND = 3'b010;
  localparam logic [2:0] C_OP_OR  = 3'b011;
  localparam logic [2:0] C_OP_XOR = 3'b100;
  localparam logic [2:0] C_OP_SLT = 3'b101;
  localparam logic [2:0] C_OP_LDI = 3'b110;
  localparam logic [2:0] C_OP_NOP = 3'b111;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [2:0]    r_op;
  logic [15:0]   r_imm;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [AW-1:0] r_addr_a;
  logic [AW-1:0] r_addr_b;
  logic [AW-1:0] r_addr_w;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_result;
  logic          r_zero;
  logic          r_ovf;
  logic          r_done;

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_alu;
  logic          w_ovf_hit;
  logic          w_skip_wb;
  logic          w_accept;

  assign w_accept = in_valid && (r_state == C_IDLE);
  assign w_sum    = r_opa + r_opb;
  assign w_diff   = r_opa - r_opb;

  always_comb begin
    w_alu = r_result;
    case (r_op)
      C_OP_ADD: w_alu = w_sum;
      C_OP_SUB: w_alu = w_diff;
      C_OP_AND: w_alu = r_opa & r_opb;
      C_OP_OR:  w_alu = r_opa | r_opb;
      C_OP_XOR: w_alu = r_opa ^ r_opb;
      C_OP_SLT: w_alu = {{(DW-1){1'b0}}, ($signed(r_opa) < $signed(r_opb))};
      C_OP_LDI: w_alu = {{(DW-16){1'b0}}, r_imm};
      default:  w_alu = r_result;
    endcase
  end

`ifdef SEQ_OVF_EN
  // Overflow: operands (B inverted for SUB) agree in sign but the result does not.
  always_comb begin
    w_ovf_hit = 1'b0;
    case (r_op)
      C_OP_ADD: w_ovf_hit = (r_opa[DW-1] == r_opb[DW-1]) && (w_sum[DW-1] != r_opa[DW-1]);
      C_OP_SUB: w_ovf_hit = (r_opa[DW-1] != r_opb[DW-1]) && (w_diff[DW-1] != r_opa[DW-1]);
      default:  w_ovf_hit = 1'b0;
    endcase
  end
`else
  assign w_ovf_hit = 1'b0;
`endif

  assign w_skip_wb = (r_op == C_OP_NOP) || w_ovf_hit;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:  w_next_state = in_valid ? C_READ : C_IDLE;
      C_READ:  w_next_state = C_EXEC;
      C_EXEC:  w_next_state = w_skip_wb ? C_IDLE : C_WB;
      C_WB:    w_next_state = C_IDLE;
      default: w_next_state = C_IDLE;
    endcase
  end

  // Write enable comes straight from the state register so it cannot glitch.
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    case (r_state)
      C_IDLE:  in_ready = 1'b1;
      C_WB:    we       = 1'b1;
      default: begin
        in_ready = 1'b0;
        we       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_op     <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_w <= '0;
      r_d      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == C_WB) || ((r_state == C_EXEC) && w_skip_wb);
      if (w_accept) begin
        r_op     <= op;
        r_imm    <= imm;
        r_addr_a <= rs;
        r_addr_b <= rt;
        r_addr_w <= rd;
      end
      if (r_state == C_READ) begin
        r_opa <= qa;
        r_opb <= qb;
      end
      if (r_state == C_EXEC) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        r_ovf    <= w_ovf_hit;
        if (!w_skip_wb) begin
          r_d <= w_alu;
        end
      end
    end
  end

  assign addr_a = r_addr_a;
  assign addr_b = r_addr_b;
  assign addr_w = r_addr_w;
  assign d      = r_d;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_regfile_exec_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_regfile_exec_seq                                               |
// | Brief   : Bench for regfile_exec_seq with an attached 8x32 register file    |
// |           and an instruction-level reference model.                         |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_regfile_exec_seq;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd, rs, rt;
  logic [15:0]   imm;
  logic [AW-1:0] addr_a, addr_b, addr_w;
  logic [DW-1:0] qa, qb, d, result;
  logic          we, done, zero, ovf;

  always #5 clk = ~clk;

  regfile_exec_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .addr_a(addr_a), .addr_b(addr_b), .qa(qa), .qb(qb),
    .we(we), .addr_w(addr_w), .d(d), .done(done),
    .result(result), .zero(zero), .ovf(ovf)
  );

  // Register file with a bench-side preload port (sequencer write has priority)
  logic [DW-1:0] rf [8];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    if (we) rf[addr_w] <= d;
    else if (pl_we) rf[pl_addr] <= pl_d;
  end
  assign qa = rf[addr_a];
  assign qb = rf[addr_b];

  // Instruction-level reference state
  logic [DW-1:0] exp_rf [8];
  logic [DW-1:0] exp_result;
  logic          exp_zero;
  logic          exp_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_we = 1'b1; pl_addr = a; pl_d = v;
    @(negedge clk);
    pl_we = 1'b0;
    exp_rf[a] = v;
  endtask

  // Entered and left at a falling edge; leaves during the done cycle.
  task automatic run(input logic [2:0] t_op, input logic [AW-1:0] t_rd, input logic [AW-1:0] t_rs,
                     input logic [AW-1:0] t_rt, input logic [15:0] t_imm, input bit keep);
    logic [DW-1:0] a, b, res;
    longint        wide;
    bit            of, eff_of, wr;
    a = exp_rf[t_rs]; b = exp_rf[t_rt]; of = 1'b0; res = exp_result;
    case (t_op)
      3'd0: begin wide = longint'($signed(a)) + longint'($signed(b)); res = a + b;
                  of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      3'd1: begin wide = longint'($signed(a)) - longint'($signed(b)); res = a - b;
                  of = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: res = {16'h0000, t_imm};
      default: res = exp_result;
    endcase
`ifdef SEQ_OVF_EN
    eff_of = of;
`else
    eff_of = 1'b0;
`endif
    wr = (t_op != 3'd7) && !eff_of;

    in_valid = 1'b1; op = t_op; rd = t_rd; rs = t_rs; rt = t_rt; imm = t_imm;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    op = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom); imm = 16'($urandom);
    chk("c1_ready", in_ready, 0);
    chk("c1_addr_a", addr_a, t_rs);
    chk("c1_addr_b", addr_b, t_rt);
    chk("c1_we", we, 0);
    chk("c1_done", done, 0);
    @(negedge clk);
    chk("c2_ready", in_ready, 0);
    chk("c2_we", we, 0);
    chk("c2_done", done, 0);
    @(negedge clk);
    if (wr) begin
      chk("c3_we", we, 1);
      chk("c3_addr_w", addr_w, t_rd);
      chk("c3_d", d, res);
      chk("c3_done", done, 0);
      chk("c3_ready", in_ready, 0);
      @(negedge clk);
    end
    exp_result = res;
    exp_zero   = (res == 0);
    exp_ovf    = eff_of;
    if (wr) exp_rf[t_rd] = res;
    chk("done_pulse", done, 1);
    chk("done_ready", in_ready, 1);
    chk("done_we", we, 0);
    chk("done_result", result, exp_result);
    chk("done_zero", zero, exp_zero);
    chk("done_ovf", ovf, exp_ovf);
    chk("done_rf_rd", rf[t_rd], exp_rf[t_rd]);
  endtask

  initial begin
    clear_n = 1'b0; in_valid = 1'b0; op = '0; rd = '0; rs = '0; rt = '0; imm = '0;
    pl_we = 1'b0; pl_addr = '0; pl_d = '0;
    exp_result = '0; exp_zero = 1'b0; exp_ovf = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_d", d, 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), $urandom);

    // Directed 1: ADD r3 = r1 + r2
    preload(3'd1, 32'd5); preload(3'd2, 32'd7);
    run(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0);
    chk("t1_r3", rf[3], 32'd12);

    // Directed 2: SUB then SLT on the negative result
    preload(3'd0, 32'd0); preload(3'd4, 32'd1);
    run(3'd1, 3'd5, 3'd0, 3'd4, 16'h0, 1'b0);
    chk("t2_r5", rf[5], 32'hFFFF_FFFF);
    chk("t2_zero", zero, 0);
    run(3'd5, 3'd6, 3'd5, 3'd4, 16'h0, 1'b0);
    chk("t2_r6", rf[6], 32'd1);

    // Directed 3: LDI then NOP
    run(3'd6, 3'd7, 3'd0, 3'd0, 16'hBEEF, 1'b0);
    chk("t3_r7", rf[7], 32'h0000_BEEF);
    run(3'd7, 3'd2, 3'd3, 3'd4, 16'h1234, 1'b0);
    chk("t3_nop_result", result, 32'h0000_BEEF);

    // Directed 4: back-to-back with in_valid held high
    run(3'd0, 3'd1, 3'd2, 3'd3, 16'h0, 1'b1);
    run(3'd4, 3'd1, 3'd1, 3'd1, 16'h0, 1'b0);
    chk("t4_r1", rf[1], 32'd0);
    chk("t4_zero", zero, 1);

    // Directed 5: reset during EXEC aborts the write
    in_valid = 1'b1; op = 3'd0; rd = 3'd2; rs = 3'd3; rt = 3'd4; imm = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("t5_ready", in_ready, 1);
    chk("t5_we", we, 0);
    chk("t5_done", done, 0);
    chk("t5_result", result, 0);
    chk("t5_addr_a", addr_a, 0);
    exp_result = '0; exp_zero = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    chk("t5_we_hold", we, 0);
    clear_n = 1'b1;
    @(negedge clk);
    chk("t5_done_after", done, 0);
    chk("t5_r2", rf[2], exp_rf[2]);

    // Directed 6: signed overflow on ADD
    preload(3'd1, 32'h7FFF_FFFF); preload(3'd2, 32'd1); preload(3'd3, 32'h0000_0033);
    run(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 1'b0);
`ifdef SEQ_OVF_EN
    chk("t6_ovf", ovf, 1);
    chk("t6_r3", rf[3], 32'h0000_0033);
`else
    chk("t6_ovf", ovf, 0);
    chk("t6_r3", rf[3], 32'h8000_0000);
`endif

    // Random instruction stream against the reference model
    for (int i = 0; i < 60; i++) begin
      run(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
          16'($urandom), (i != 59) && ($urandom_range(0, 1) == 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], exp_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
